unified_mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the instruction-fetch port and the data (load/store) port.

---
 rtl/unified_mem_arbiter_pkg.sv | 16 +
 rtl/unified_mem_arbiter_starve_counter.sv | 26 ++
 rtl/unified_mem_arbiter.sv | 101 ++++++++++
 tb/tb_unified_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states and grant ids.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEM_I = 2'd1,
    ST_MEM_D = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating count of back-to-back data grants taken while a fetch was waiting.
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != CNT_W'(LIMIT)))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_at_limit = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by instruction fetch and data load/store; data wins
// by default, a starvation limit forces a fetch grant after repeated data grants.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_e r_state, w_next;
  logic       r_gnt;
  logic       w_grant_d, w_grant_i, w_at_limit, w_inc, w_clr, w_busy;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT), .CNT_W(STARVE_CNT_W)) u_starve (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_inc),
    .i_clr      (w_clr),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if ((d_rd || d_wr) && (!if_req || !w_at_limit)) begin
          w_grant_d = 1'b1;
          w_next    = ST_MEM_D;
        end else if (if_req) begin
          w_grant_i = 1'b1;
          w_next    = ST_MEM_I;
        end
      end
      ST_MEM_I, ST_MEM_D: if (mem_ack) w_next = ST_RESP;
      // Requests are deliberately not looked at here: a held request from the
      // port just served must not be re-granted.
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_inc    = w_grant_d && if_req;
  assign w_clr    = w_grant_i || (w_grant_d && !if_req);
  assign w_busy   = (r_state == ST_MEM_I) || (r_state == ST_MEM_D);
  assign if_ready = (r_state == ST_RESP) && (r_gnt == GNT_IF);
  assign d_ready  = (r_state == ST_RESP) && (r_gnt == GNT_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      r_gnt     <= GNT_IF;
    end else begin
      if (w_grant_d || w_grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= w_grant_d && d_wr;
        mem_addr  <= w_grant_d ? d_addr : if_addr;
        mem_wdata <= d_wdata;
        r_gnt     <= w_grant_d ? GNT_D : GNT_IF;
      end
      if (w_busy && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (r_state == ST_MEM_I) if_rdata <= mem_rdata;
        else if (!mem_we)        d_rdata  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: vector table of single transactions plus contention, stale
// request and reset-abort sequences against a small memory model.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req = 0, d_rd = 0, d_wr = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_req, mem_we, mem_ack;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // memory model: ack after ack_dly wait cycles, driven on the falling edge
  logic [31:0] mem [logic [31:0]];
  int          ack_dly = 0, wcnt = 0;
  logic        mem_en = 1'b1, model_ack = 0, man_ack = 0;
  logic [31:0] model_rdata = 0, man_rdata = 0;
  assign mem_ack   = mem_en ? model_ack : man_ack;
  assign mem_rdata = mem_en ? model_rdata : man_rdata;

  always @(negedge clk) begin
    model_ack = 1'b0;
    if (mem_req) begin
      if (wcnt == ack_dly) begin
        model_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        model_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  // monitor: transaction starts, grant order, mem_* stability, ready spacing
  int   txn_cnt = 0, memcyc_cnt = 0, if_rdy_cnt = 0, d_rdy_cnt = 0, stab_err = 0, consec_err = 0;
  logic last_we = 0, p_req = 0, p_we = 0, p_rdy = 0;
  logic [31:0] p_addr = 0;
  logic grants[$];

  always @(posedge clk) begin
    #2;
    if (mem_req && !p_req) begin
      txn_cnt++;
      last_we = mem_we;
      grants.push_back(mem_addr == 32'h1000);
    end
    if (mem_req && p_req && (mem_addr != p_addr || mem_we != p_we)) stab_err++;
    if ((if_ready || d_ready) && p_rdy) consec_err++;
    if (mem_req) memcyc_cnt++;
    if (if_ready) if_rdy_cnt++;
    if (d_ready) d_rdy_cnt++;
    p_req = mem_req; p_we = mem_we; p_addr = mem_addr; p_rdy = if_ready || d_ready;
  end

  typedef struct {
    logic        is_if;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] exp_if = 0, exp_d = 0;

  task automatic run_vec(input int idx, input vec_t v);
    int n = 0;
    bit got = 0;
    int ir0 = if_rdy_cnt, dr0 = d_rdy_cnt, mc0 = memcyc_cnt;
    ack_dly = v.dly;
    if (v.is_if) begin
      if_req = 1; if_addr = v.addr;
    end else begin
      d_rd = !v.is_wr; d_wr = v.is_wr; d_addr = v.addr; d_wdata = v.wdata;
    end
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (if_ready || d_ready) got = 1;
    end
    if_req = 0; d_rd = 0; d_wr = 0;
    chk($sformatf("v%0d_latency", idx), n, 2 + v.dly);
    if (v.is_if) exp_if = v.exp_rdata;
    else if (!v.is_wr) exp_d = v.exp_rdata;
    chk($sformatf("v%0d_if_rdata", idx), if_rdata, exp_if);
    chk($sformatf("v%0d_d_rdata", idx), d_rdata, exp_d);
    @(posedge clk); #1;
    chk($sformatf("v%0d_if_ready_cnt", idx), if_rdy_cnt - ir0, v.is_if ? 1 : 0);
    chk($sformatf("v%0d_d_ready_cnt", idx), d_rdy_cnt - dr0, v.is_if ? 0 : 1);
    chk($sformatf("v%0d_mem_cycles", idx), memcyc_cnt - mc0, 1 + v.dly);
    chk($sformatf("v%0d_mem_we", idx), last_we, v.is_wr);
  endtask

  task automatic wait_ready(output bit got);
    int n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (if_ready || d_ready) got = 1;
    end
  endtask

  initial begin
    int  n, t0, r0;
    bit  got;
    logic [31:0] rd_before;

    mem[32'h40]   = 32'h2402000A;
    mem[32'h200]  = 32'h12345678;
    mem[32'h1000] = 32'h0BADF00D;
    mem[32'h2000] = 32'hCAFE0001;

    vecs[0] = '{1'b1, 1'b0, 32'h40,       32'h0,        0, 32'h2402000A};
    vecs[1] = '{1'b0, 1'b1, 32'h100,      32'hDEADBEEF, 0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h100,      32'h0,        0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h1000,     32'h0,        3, 32'h0BADF00D};
    vecs[4] = '{1'b0, 1'b0, 32'h200,      32'h0,        1, 32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'hA5A55A5A, 2, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        0, 32'hA5A55A5A};
    vecs[7] = '{1'b1, 1'b0, 32'h40,       32'h0,        2, 32'h2402000A};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ready", {if_ready, d_ready}, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);
    chk("mem_stable", stab_err, 0);

    // contention: both held, grant order D,D,D,D,I repeating
    ack_dly = 0;
    grants.delete();
    consec_err = 0;
    if_addr = 32'h1000; d_addr = 32'h2000;
    if_req = 1; d_rd = 1;
    n = 0; t0 = 0;
    while (n < 10 && t0 < 100) begin
      @(posedge clk); #1; t0++;
      if (if_ready || d_ready) n++;
    end
    if_req = 0; d_rd = 0;
    @(posedge clk); #1;
    chk("cont_grants", grants.size(), 10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk($sformatf("cont_grant%0d", i), grants[i], (i % 5 == 4) ? 1 : 0);
    chk("cont_no_b2b_ready", consec_err, 0);

    // stale request: held one cycle past d_ready, then dropped
    t0 = txn_cnt; r0 = d_rdy_cnt;
    d_addr = 32'h200; d_rd = 1;
    wait_ready(got);
    chk("stale1_ready", got, 1);
    @(posedge clk); #1;
    d_rd = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("stale1_txns", txn_cnt - t0, 1);
    chk("stale1_readies", d_rdy_cnt - r0, 1);

    // held into the IDLE cycle: a second transaction follows
    t0 = txn_cnt; r0 = d_rdy_cnt;
    d_rd = 1;
    wait_ready(got);
    @(posedge clk); #1;
    wait_ready(got);
    chk("stale2_ready", got, 1);
    d_rd = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("stale2_txns", txn_cnt - t0, 2);
    chk("stale2_readies", d_rdy_cnt - r0, 2);

    // reset mid MEM_D, then a late ack
    mem_en = 0;
    r0 = d_rdy_cnt;
    d_addr = 32'h300; d_rd = 1;
    @(posedge clk); #1;
    chk("abort_mem_req_up", mem_req, 1);
    chk("abort_state_memd", 32'(dut.r_state), 32'(ST_MEM_D));
    reset = 1;
    @(posedge clk); #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
    reset = 0; d_rd = 0;
    rd_before = d_rdata;
    @(negedge clk);
    man_ack = 1; man_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    man_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_ready", d_rdy_cnt - r0, 0);
    chk("abort_d_rdata", d_rdata, rd_before);
    chk("abort_d_rdata_zero", d_rdata, 0);
    chk("abort_idle", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
